mem_req_arbiter: RTL

//  Shares the single DDR2 request path of the memory subsystem between icache

---
 rtl/mem_req_arbiter_if.sv | 51 +++++
 rtl/mem_req_arbiter.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_req_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : mem_req_arbiter_if
//  Description : Cache-side and DDR-side handshake bundle for mem_req_arbiter.
//                slave  = arbiter view, master = cache/DDR environment view.
//  Revision    : 1.0 - initial release
// ============================================================================
interface mem_req_arbiter_if;
  // icache fill port
  logic         ic_req;
  logic [26:0]  ic_addr;
  logic         ic_ack;
  logic [255:0] ic_rdata;
  // dcache fill / writeback port
  logic         dc_req;
  logic         dc_we;
  logic [26:0]  dc_addr;
  logic [255:0] dc_wdata;
  logic         dc_ack;
  logic [255:0] dc_rdata;
  // DDR2 command channel
  logic         mem_cmd_valid;
  logic         mem_cmd_ready;
  logic         mem_cmd_rnw;
  logic [30:0]  mem_cmd_addr;
  // DDR2 write-data channel
  logic         mem_wdf_valid;
  logic         mem_wdf_ready;
  logic [127:0] mem_wdf_data;
  logic [15:0]  mem_wdf_mask;
  // DDR2 read-data channel (no backpressure)
  logic         mem_rdf_valid;
  logic [127:0] mem_rdf_data;

  modport slave (
    input  ic_req, ic_addr, dc_req, dc_we, dc_addr, dc_wdata,
           mem_cmd_ready, mem_wdf_ready, mem_rdf_valid, mem_rdf_data,
    output ic_ack, ic_rdata, dc_ack, dc_rdata,
           mem_cmd_valid, mem_cmd_rnw, mem_cmd_addr,
           mem_wdf_valid, mem_wdf_data, mem_wdf_mask
  );

  modport master (
    output ic_req, ic_addr, dc_req, dc_we, dc_addr, dc_wdata,
           mem_cmd_ready, mem_wdf_ready, mem_rdf_valid, mem_rdf_data,
    input  ic_ack, ic_rdata, dc_ack, dc_rdata,
           mem_cmd_valid, mem_cmd_rnw, mem_cmd_addr,
           mem_wdf_valid, mem_wdf_data, mem_wdf_mask
  );
endinterface
`default_nettype wire

// File: rtl/mem_req_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_req_arbiter
//  Description : Shares the DDR2 request path between icache fills and dcache
//                fills/writebacks. One transaction in flight; round-robin on
//                ties; stall-timeout and stray-beat error flags.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_req_arbiter #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = 11
) (
  input  wire              clk,
  input  wire              rst_n,
  mem_req_arbiter_if.slave bus,
  output logic             busy,
  output logic             err_timeout,
  output logic             err_stray
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WR_B0  = 3'd1,
    ST_WR_B1  = 3'd2,
    ST_WR_CMD = 3'd3,
    ST_RD_CMD = 3'd4,
    ST_RD_B0  = 3'd5,
    ST_RD_B1  = 3'd6,
    ST_RESP   = 3'd7
  } state_t;

  localparam logic [CNT_W-1:0] c_STALL_HIT = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_STALL_MAX = '1;

  state_t       r_state;
  logic         r_gnt_dc;      // 1 = current transaction belongs to dcache
  logic         r_last_dc;     // 1 = last completed grant was dcache
  logic         r_rnw;
  logic [26:0]  r_addr;
  logic [127:0] r_wdata_hi;    // second write beat, parked until beat 0 goes
  logic [127:0] r_line_lo;     // first read beat, parked until beat 1 arrives
  logic         r_ic_ack;
  logic         r_dc_ack;
  logic [255:0] r_ic_rdata;
  logic [255:0] r_dc_rdata;
  logic         r_cmd_valid;
  logic         r_wdf_valid;
  logic [127:0] r_wdf_data;
  logic         r_busy;
  logic [CNT_W-1:0] r_stall;
  logic         r_err_timeout;
  logic         r_err_stray;

  logic w_cmd_fire;
  logic w_wdf_fire;
  logic w_in_rd_beat;
  logic w_pick_dc;
  logic w_any_req;
  logic w_advance;

  assign w_cmd_fire   = r_cmd_valid & bus.mem_cmd_ready;
  assign w_wdf_fire   = r_wdf_valid & bus.mem_wdf_ready;
  assign w_in_rd_beat = (r_state == ST_RD_B0) || (r_state == ST_RD_B1);
  assign w_any_req    = bus.ic_req | bus.dc_req;
  // dcache wins when alone, or on a tie when icache had the previous grant
  assign w_pick_dc    = bus.dc_req & (~bus.ic_req | ~r_last_dc);

  // Whether the current non-IDLE state leaves this cycle
  always_comb begin
    w_advance = 1'b0;
    case (r_state)
      ST_WR_B0, ST_WR_B1:   w_advance = w_wdf_fire;
      ST_WR_CMD, ST_RD_CMD: w_advance = w_cmd_fire;
      ST_RD_B0, ST_RD_B1:   w_advance = bus.mem_rdf_valid;
      ST_RESP:              w_advance = 1'b1;
      default:              w_advance = 1'b0;
    endcase
  end

  // Transaction FSM with registered handshake outputs and return data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_gnt_dc    <= 1'b0;
      r_last_dc   <= 1'b0;
      r_rnw       <= 1'b0;
      r_addr      <= '0;
      r_wdata_hi  <= '0;
      r_line_lo   <= '0;
      r_ic_ack    <= 1'b0;
      r_dc_ack    <= 1'b0;
      r_ic_rdata  <= '0;
      r_dc_rdata  <= '0;
      r_cmd_valid <= 1'b0;
      r_wdf_valid <= 1'b0;
      r_wdf_data  <= '0;
      r_busy      <= 1'b0;
    end else begin
      r_ic_ack <= 1'b0;
      r_dc_ack <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_any_req) begin
            r_gnt_dc <= w_pick_dc;
            r_busy   <= 1'b1;
            if (w_pick_dc) begin
              r_addr     <= bus.dc_addr;
              r_rnw      <= ~bus.dc_we;
              r_wdf_data <= bus.dc_wdata[127:0];
              r_wdata_hi <= bus.dc_wdata[255:128];
            end else begin
              r_addr <= bus.ic_addr;
              r_rnw  <= 1'b1;
            end
            // write beats go first so the command never precedes its data
            if (w_pick_dc && bus.dc_we) begin
              r_wdf_valid <= 1'b1;
              r_state     <= ST_WR_B0;
            end else begin
              r_cmd_valid <= 1'b1;
              r_state     <= ST_RD_CMD;
            end
          end
        end
        ST_WR_B0: begin
          if (w_wdf_fire) begin
            r_wdf_data <= r_wdata_hi;
            r_state    <= ST_WR_B1;
          end
        end
        ST_WR_B1: begin
          if (w_wdf_fire) begin
            r_wdf_valid <= 1'b0;
            r_cmd_valid <= 1'b1;
            r_state     <= ST_WR_CMD;
          end
        end
        ST_WR_CMD: begin
          if (w_cmd_fire) begin
            r_cmd_valid <= 1'b0;
            r_dc_ack    <= r_gnt_dc;
            r_ic_ack    <= ~r_gnt_dc;
            r_state     <= ST_RESP;
          end
        end
        ST_RD_CMD: begin
          if (w_cmd_fire) begin
            r_cmd_valid <= 1'b0;
            r_state     <= ST_RD_B0;
          end
        end
        ST_RD_B0: begin
          if (bus.mem_rdf_valid) begin
            r_line_lo <= bus.mem_rdf_data;
            r_state   <= ST_RD_B1;
          end
        end
        ST_RD_B1: begin
          if (bus.mem_rdf_valid) begin
            if (r_gnt_dc) begin
              r_dc_rdata <= {bus.mem_rdf_data, r_line_lo};
              r_dc_ack   <= 1'b1;
            end else begin
              r_ic_rdata <= {bus.mem_rdf_data, r_line_lo};
              r_ic_ack   <= 1'b1;
            end
            r_state <= ST_RESP;
          end
        end
        ST_RESP: begin
          r_last_dc <= r_gnt_dc;
          r_busy    <= 1'b0;
          r_state   <= ST_IDLE;
        end
        default: begin
          r_cmd_valid <= 1'b0;
          r_wdf_valid <= 1'b0;
          r_busy      <= 1'b0;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  // Stall counter: counts cycles spent waiting in one state; sticky timeout
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall       <= '0;
      r_err_timeout <= 1'b0;
    end else if ((r_state == ST_IDLE) || w_advance) begin
      r_stall <= '0;
    end else begin
      if (r_stall != c_STALL_MAX) begin
        r_stall <= r_stall + CNT_W'(1);
      end
      if (r_stall == c_STALL_HIT) begin
        r_err_timeout <= 1'b1;
      end
    end
  end

  // Sticky flag for read beats that arrive when no read beat is expected
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_stray <= 1'b0;
    end else if (bus.mem_rdf_valid && !w_in_rd_beat) begin
      r_err_stray <= 1'b1;
    end
  end

  assign bus.ic_ack        = r_ic_ack;
  assign bus.ic_rdata      = r_ic_rdata;
  assign bus.dc_ack        = r_dc_ack;
  assign bus.dc_rdata      = r_dc_rdata;
  assign bus.mem_cmd_valid = r_cmd_valid;
  assign bus.mem_cmd_rnw   = r_rnw;
  assign bus.mem_cmd_addr  = {2'b00, r_addr, 2'b00};
  assign bus.mem_wdf_valid = r_wdf_valid;
  assign bus.mem_wdf_data  = r_wdf_data;
  assign bus.mem_wdf_mask  = 16'h0000;
  assign busy              = r_busy;
  assign err_timeout       = r_err_timeout;
  assign err_stray         = r_err_stray;

endmodule
`default_nettype wire
